// File: rtl/fetch_pkg.sv
// Shared constants and state encoding for the instruction fetch stage.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package fetch_pkg;

   localparam int ADDR_W   = 6;
   localparam int WORD_W   = 16;
   localparam int LONG_BIT = 15;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      HOLD = 2'd2
   } fetch_state_t;

endpackage

// File: rtl/fetch_output_stage.sv
// Valid/ready holding register between fetch and decode, with flush.
// Latency: one cycle from load to valid.
// Backpressure: contents held stable while valid && !ready; flush drops them.
module fetch_output_stage
   import fetch_pkg::*;
#(
   parameter int ADDR_W = fetch_pkg::ADDR_W,
   parameter int WORD_W = fetch_pkg::WORD_W
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  flush,
   input  logic                  load,
   input  logic [2*WORD_W-1:0]   load_instruction,
   input  logic                  load_is_long,
   input  logic [ADDR_W-1:0]     load_pc,
   input  logic                  ready,
   output logic                  valid,
   output logic [2*WORD_W-1:0]   instruction,
   output logic                  is_long,
   output logic [ADDR_W-1:0]     pc
);

   // Flush beats load; a load replaces any consumed entry in the same cycle.
   always_ff @(posedge clock) begin
      if (reset) begin
         valid       <= 1'b0;
         instruction <= '0;
         is_long     <= 1'b0;
         pc          <= '0;
      end else if (flush) begin
         valid <= 1'b0;
      end else if (load) begin
         valid       <= 1'b1;
         instruction <= load_instruction;
         is_long     <= load_is_long;
         pc          <= load_pc;
      end else if (ready) begin
         valid <= 1'b0;
      end
   end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: PC, 16/32-bit assembly from two memory ports; INSTRUCTION_FETCH_COUNT_EN adds fetch_count.
// Latency: one cycle pc -> fetch_valid; branch target valid two cycles after the branch cycle.
// Backpressure: fetch_ready=0 with a full output holds pc and outputs (HOLD); no bubble on release.
module instruction_fetch_unit
   import fetch_pkg::*;
#(
   parameter int                ADDR_W   = fetch_pkg::ADDR_W,
   parameter int                WORD_W   = fetch_pkg::WORD_W,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  fetch_enable,
   input  logic                  branch_valid,
   input  logic [ADDR_W-1:0]     branch_target,
   output logic [ADDR_W-1:0]     instruction_rd1,
   output logic [ADDR_W-1:0]     instruction_rd2,
   input  logic [WORD_W-1:0]     instruction_rd1_out,
   input  logic [WORD_W-1:0]     instruction_rd2_out,
   output logic                  fetch_valid,
   input  logic                  fetch_ready,
   output logic [2*WORD_W-1:0]   fetch_instruction,
   output logic                  fetch_is_long,
   output logic [ADDR_W-1:0]     fetch_pc
`ifdef INSTRUCTION_FETCH_COUNT_EN
   ,
   output logic [31:0]           fetch_count
`endif
);

   localparam logic [ADDR_W-1:0] PC_ONE = ADDR_W'(1);
   localparam logic [ADDR_W-1:0] PC_TWO = ADDR_W'(2);

   fetch_state_t          state, state_next;
   logic [ADDR_W-1:0]     pc, pc_next;
   logic                  slot_free;
   logic                  capture;
   logic                  word_is_long;
   logic [2*WORD_W-1:0]   assembled;

   assign instruction_rd1 = pc;
   assign instruction_rd2 = pc + PC_ONE;

   assign slot_free    = !fetch_valid || fetch_ready;
   assign word_is_long = instruction_rd1_out[LONG_BIT];
   assign assembled    = word_is_long ? {instruction_rd1_out, instruction_rd2_out}
                                      : {instruction_rd1_out, {WORD_W{1'b0}}};

   // Next-state, next-pc and capture decision; branch outranks everything but reset.
   always_comb begin
      state_next = state;
      pc_next    = pc;
      capture    = 1'b0;
      if (branch_valid) begin
         pc_next    = branch_target;
         state_next = fetch_enable ? RUN : IDLE;
      end else if (!fetch_enable) begin
         state_next = (fetch_valid && !fetch_ready) ? HOLD : IDLE;
      end else begin
         case (state)
            IDLE: state_next = RUN;
            RUN, HOLD: begin
               if (slot_free) begin
                  capture    = 1'b1;
                  pc_next    = pc + (word_is_long ? PC_TWO : PC_ONE);
                  state_next = RUN;
               end else begin
                  state_next = HOLD;
               end
            end
            default: state_next = IDLE;
         endcase
      end
   end

   // PC and FSM state registers.
   always_ff @(posedge clock) begin
      if (reset) begin
         pc    <= RESET_PC;
         state <= IDLE;
      end else begin
         pc    <= pc_next;
         state <= state_next;
      end
   end

   fetch_output_stage #(
      .ADDR_W (ADDR_W),
      .WORD_W (WORD_W)
   ) u_output_stage (
      .clock            (clock),
      .reset            (reset),
      .flush            (branch_valid),
      .load             (capture),
      .load_instruction (assembled),
      .load_is_long     (word_is_long),
      .load_pc          (pc),
      .ready            (fetch_ready),
      .valid            (fetch_valid),
      .instruction      (fetch_instruction),
      .is_long          (fetch_is_long),
      .pc               (fetch_pc)
   );

`ifdef INSTRUCTION_FETCH_COUNT_EN
   // Count instructions actually handed to decode; a branch voids the handshake.
   always_ff @(posedge clock) begin
      if (reset) begin
         fetch_count <= 32'd0;
      end else if (fetch_valid && fetch_ready && !branch_valid) begin
         fetch_count <= fetch_count + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit with a combinational 64x16 memory model.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
// Expected values are hand-computed per scenario.
module tb_instruction_fetch_unit;

   logic        clock;
   logic        reset;
   logic        fetch_enable;
   logic        branch_valid;
   logic [5:0]  branch_target;
   logic [5:0]  instruction_rd1;
   logic [5:0]  instruction_rd2;
   logic [15:0] instruction_rd1_out;
   logic [15:0] instruction_rd2_out;
   logic        fetch_valid;
   logic        fetch_ready;
   logic [31:0] fetch_instruction;
   logic        fetch_is_long;
   logic [5:0]  fetch_pc;
`ifdef INSTRUCTION_FETCH_COUNT_EN
   logic [31:0] fetch_count;
`endif

   logic [15:0] mem [64];
   int          passed;
   int          total;

   assign instruction_rd1_out = mem[instruction_rd1];
   assign instruction_rd2_out = mem[instruction_rd2];

   instruction_fetch_unit dut (
      .clock               (clock),
      .reset               (reset),
      .fetch_enable        (fetch_enable),
      .branch_valid        (branch_valid),
      .branch_target       (branch_target),
      .instruction_rd1     (instruction_rd1),
      .instruction_rd2     (instruction_rd2),
      .instruction_rd1_out (instruction_rd1_out),
      .instruction_rd2_out (instruction_rd2_out),
      .fetch_valid         (fetch_valid),
      .fetch_ready         (fetch_ready),
      .fetch_instruction   (fetch_instruction),
      .fetch_is_long       (fetch_is_long),
      .fetch_pc            (fetch_pc)
`ifdef INSTRUCTION_FETCH_COUNT_EN
      ,
      .fetch_count         (fetch_count)
`endif
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic do_reset();
      reset        = 1'b1;
      fetch_enable = 1'b1;
      fetch_ready  = 1'b1;
      branch_valid = 1'b0;
      step();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      for (int i = 0; i < 64; i++) mem[i] = 16'h0100;
      reset = 1'b1; fetch_enable = 1'b1; fetch_ready = 1'b1;
      branch_valid = 1'b0; branch_target = 6'd0;
      step();
      step();
      total++; if (fetch_valid !== 1'b0) $display("FAIL reset_valid: got %b expected 0", fetch_valid); else passed++;
      total++; if (fetch_instruction !== 32'h0) $display("FAIL reset_instr: got %h expected 00000000", fetch_instruction); else passed++;
      total++; if (fetch_is_long !== 1'b0) $display("FAIL reset_long: got %b expected 0", fetch_is_long); else passed++;
      total++; if (fetch_pc !== 6'd0) $display("FAIL reset_fetch_pc: got %0d expected 0", fetch_pc); else passed++;
      total++; if (instruction_rd1 !== 6'd0) $display("FAIL reset_rd1: got %0d expected 0", instruction_rd1); else passed++;
      total++; if (instruction_rd2 !== 6'd1) $display("FAIL reset_rd2: got %0d expected 1", instruction_rd2); else passed++;
      reset = 1'b0;
   endtask

   task automatic test_sequential();
      step();
      total++; if (fetch_valid !== 1'b0) $display("FAIL seq_idle_bubble: got %b expected 0", fetch_valid); else passed++;
      for (int i = 0; i < 4; i++) begin
         step();
         total++; if (fetch_valid !== 1'b1) $display("FAIL seq_valid[%0d]: got %b expected 1", i, fetch_valid); else passed++;
         total++; if (fetch_pc !== 6'(i)) $display("FAIL seq_pc[%0d]: got %0d expected %0d", i, fetch_pc, i); else passed++;
         total++; if (fetch_instruction !== 32'h01000000) $display("FAIL seq_instr[%0d]: got %h expected 01000000", i, fetch_instruction); else passed++;
         total++; if (fetch_is_long !== 1'b0) $display("FAIL seq_long[%0d]: got %b expected 0", i, fetch_is_long); else passed++;
      end
   endtask

   task automatic test_long();
      mem[4] = 16'h8123;
      mem[5] = 16'h4567;
      branch_valid = 1'b1; branch_target = 6'd4;
      step();
      branch_valid = 1'b0;
      total++; if (fetch_valid !== 1'b0) $display("FAIL long_flush: got %b expected 0", fetch_valid); else passed++;
      step();
      total++; if (fetch_pc !== 6'd4) $display("FAIL long_pc: got %0d expected 4", fetch_pc); else passed++;
      total++; if (fetch_instruction !== 32'h81234567) $display("FAIL long_instr: got %h expected 81234567", fetch_instruction); else passed++;
      total++; if (fetch_is_long !== 1'b1) $display("FAIL long_flag: got %b expected 1", fetch_is_long); else passed++;
      step();
      total++; if (fetch_pc !== 6'd6) $display("FAIL long_next_pc: got %0d expected 6", fetch_pc); else passed++;
      total++; if (fetch_is_long !== 1'b0) $display("FAIL long_next_flag: got %b expected 0", fetch_is_long); else passed++;
   endtask

   task automatic test_hold();
      do_reset();
      step(); step(); step(); step();
      total++; if (fetch_pc !== 6'd2) $display("FAIL hold_setup_pc: got %0d expected 2", fetch_pc); else passed++;
      fetch_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         total++; if (fetch_valid !== 1'b1) $display("FAIL hold_valid[%0d]: got %b expected 1", i, fetch_valid); else passed++;
         total++; if (fetch_pc !== 6'd2) $display("FAIL hold_pc[%0d]: got %0d expected 2", i, fetch_pc); else passed++;
         total++; if (instruction_rd1 !== 6'd3) $display("FAIL hold_rd1[%0d]: got %0d expected 3", i, instruction_rd1); else passed++;
         total++; if (fetch_instruction !== 32'h01000000) $display("FAIL hold_instr[%0d]: got %h expected 01000000", i, fetch_instruction); else passed++;
      end
      fetch_ready = 1'b1;
      step();
      total++; if (fetch_valid !== 1'b1) $display("FAIL hold_release_valid: got %b expected 1", fetch_valid); else passed++;
      total++; if (fetch_pc !== 6'd3) $display("FAIL hold_release_pc: got %0d expected 3", fetch_pc); else passed++;
   endtask

   task automatic test_branch();
      fetch_ready = 1'b0;
      branch_valid = 1'b1; branch_target = 6'd10;
      step();
      branch_valid = 1'b0;
      step();
      step();
      total++; if (fetch_valid !== 1'b1) $display("FAIL br_hold_valid: got %b expected 1", fetch_valid); else passed++;
      total++; if (fetch_pc !== 6'd10) $display("FAIL br_hold_pc: got %0d expected 10", fetch_pc); else passed++;
      total++; if (instruction_rd1 !== 6'd11) $display("FAIL br_hold_rd1: got %0d expected 11", instruction_rd1); else passed++;
      branch_valid = 1'b1; branch_target = 6'd40; fetch_ready = 1'b1;
      step();
      branch_valid = 1'b0;
      total++; if (fetch_valid !== 1'b0) $display("FAIL br_flush_valid: got %b expected 0", fetch_valid); else passed++;
      total++; if (instruction_rd1 !== 6'd40) $display("FAIL br_target_rd1: got %0d expected 40", instruction_rd1); else passed++;
      step();
      total++; if (fetch_valid !== 1'b1) $display("FAIL br_target_valid: got %b expected 1", fetch_valid); else passed++;
      total++; if (fetch_pc !== 6'd40) $display("FAIL br_target_pc: got %0d expected 40", fetch_pc); else passed++;
   endtask

   task automatic test_wrap();
      mem[63] = 16'h8001;
      mem[0]  = 16'h00AA;
      branch_valid = 1'b1; branch_target = 6'd63;
      step();
      branch_valid = 1'b0;
      total++; if (instruction_rd2 !== 6'd0) $display("FAIL wrap_rd2: got %0d expected 0", instruction_rd2); else passed++;
      step();
      total++; if (fetch_instruction !== 32'h800100AA) $display("FAIL wrap_instr: got %h expected 800100aa", fetch_instruction); else passed++;
      total++; if (fetch_is_long !== 1'b1) $display("FAIL wrap_long: got %b expected 1", fetch_is_long); else passed++;
      total++; if (fetch_pc !== 6'd63) $display("FAIL wrap_pc: got %0d expected 63", fetch_pc); else passed++;
      total++; if (instruction_rd1 !== 6'd1) $display("FAIL wrap_rd1: got %0d expected 1", instruction_rd1); else passed++;
      step();
      total++; if (fetch_pc !== 6'd1) $display("FAIL wrap_next_pc: got %0d expected 1", fetch_pc); else passed++;
   endtask

   task automatic test_enable();
      do_reset();
      step(); step(); step();
      fetch_enable = 1'b0; fetch_ready = 1'b0;
      step();
      total++; if (fetch_valid !== 1'b1) $display("FAIL en_held_valid: got %b expected 1", fetch_valid); else passed++;
      total++; if (fetch_pc !== 6'd1) $display("FAIL en_held_pc: got %0d expected 1", fetch_pc); else passed++;
      fetch_ready = 1'b1;
      step();
      total++; if (fetch_valid !== 1'b0) $display("FAIL en_drain_valid: got %b expected 0", fetch_valid); else passed++;
      total++; if (instruction_rd1 !== 6'd2) $display("FAIL en_drain_rd1: got %0d expected 2", instruction_rd1); else passed++;
      step();
      total++; if (fetch_valid !== 1'b0) $display("FAIL en_idle_valid: got %b expected 0", fetch_valid); else passed++;
      fetch_enable = 1'b1;
      step();
      total++; if (fetch_valid !== 1'b0) $display("FAIL en_restart_bubble: got %b expected 0", fetch_valid); else passed++;
      step();
      total++; if (fetch_valid !== 1'b1) $display("FAIL en_restart_valid: got %b expected 1", fetch_valid); else passed++;
      total++; if (fetch_pc !== 6'd2) $display("FAIL en_restart_pc: got %0d expected 2", fetch_pc); else passed++;
   endtask

   task automatic test_reset_in_hold();
      do_reset();
      step(); step(); step();
      fetch_ready = 1'b0;
      step();
      total++; if (fetch_pc !== 6'd1) $display("FAIL rh_setup_pc: got %0d expected 1", fetch_pc); else passed++;
`ifdef INSTRUCTION_FETCH_COUNT_EN
      total++; if (fetch_count !== 32'd1) $display("FAIL rh_count_before: got %0d expected 1", fetch_count); else passed++;
`endif
      reset = 1'b1;
      step();
      total++; if (fetch_valid !== 1'b0) $display("FAIL rh_valid: got %b expected 0", fetch_valid); else passed++;
      total++; if (instruction_rd1 !== 6'd0) $display("FAIL rh_rd1: got %0d expected 0", instruction_rd1); else passed++;
      total++; if (fetch_instruction !== 32'h0) $display("FAIL rh_instr: got %h expected 00000000", fetch_instruction); else passed++;
      total++; if (fetch_pc !== 6'd0) $display("FAIL rh_fetch_pc: got %0d expected 0", fetch_pc); else passed++;
`ifdef INSTRUCTION_FETCH_COUNT_EN
      total++; if (fetch_count !== 32'd0) $display("FAIL rh_count: got %0d expected 0", fetch_count); else passed++;
`endif
      reset = 1'b0; fetch_ready = 1'b1;
      step();
      total++; if (fetch_valid !== 1'b0) $display("FAIL rh_idle_bubble: got %b expected 0", fetch_valid); else passed++;
      step();
      total++; if (fetch_valid !== 1'b1) $display("FAIL rh_restart_valid: got %b expected 1", fetch_valid); else passed++;
      total++; if (fetch_pc !== 6'd0) $display("FAIL rh_restart_pc: got %0d expected 0", fetch_pc); else passed++;
   endtask

   initial begin
      passed = 0;
      total  = 0;
      test_reset();
      test_sequential();
      test_long();
      test_hold();
      test_branch();
      test_wrap();
      test_enable();
      test_reset_in_hold();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
